align_rdq: RTL and testbench

Request front-end that sits directly upstream of the word-align/deep-sleep stage and issues its read, write, addr and din signals. It runs a valid/ready client handshake and tracks in-flight reads through the fixed SRAM_DELAY+FLOPMEM pipeline. Read data, serr and padr are captured into a credit-protected response FIFO so the client can backpressure without losing returns. An optional parity-error log records the first failing physical address and keeps a saturating error count.

---
 rtl/align_pkg.sv | 19 +
 rtl/align_rdq_chk.sv | 26 ++
 rtl/align_rdq_fifo.sv | 112 +++++++++++
 rtl/align_rdq.sv | 197 +++++++++++++++++++
 tb/tb_align_rdq.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/align_pkg.sv
// align_pkg: shared types and helpers for the align_rdq request front-end.
// rdq_rsp_t is the canonical response layout captured from the align stage.
package align_pkg;

  localparam int RDQ_WIDTH   = 32;
  localparam int RDQ_BITPADR = 10;

  typedef struct packed {
    logic [RDQ_WIDTH-1:0]   dout;
    logic                   serr;
    logic [RDQ_BITPADR-1:0] padr;
  } rdq_rsp_t;

  // Cycles from an accepted read to the align stage presenting its data.
  function automatic int rdq_lat(input int sram_delay, input int flopmem);
    return sram_delay + flopmem;
  endfunction

endpackage

// File: rtl/align_rdq_chk.sv
// align_rdq_chk: protocol checks for align_rdq (FIFO overflow/underflow,
// accepted address range). Contains assertions only, no design logic.
module align_rdq_chk #(
  parameter int NUMADDR = 1024,
  parameter int BITADDR = 10
) (
  input logic               clk,
  input logic               rst,
  input logic               fifo_push,
  input logic               fifo_full,
  input logic               fifo_pop,
  input logic               fifo_empty,
  input logic               req_acc,
  input logic [BITADDR-1:0] req_addr
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_pop && fifo_empty));

  a_addr_range: assert property (@(posedge clk) disable iff (rst)
    req_acc |-> (32'(req_addr) < NUMADDR));

endmodule

// File: rtl/align_rdq_fifo.sv
// align_rdq_fifo: DEPTH-entry circular response FIFO with a registered head.
// The head register is refreshed every cycle from the next-state queue, so a
// word pushed at cycle T is visible on out_vld/out_data at T+1.
module align_rdq_fifo
  import align_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type rsp_t = rdq_rsp_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rsp_t wdata,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic out_vld,
  output rsp_t out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rsp_t          mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_nxt_s;
  logic [PW-1:0] rd_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          push_s;
  logic          pop_s;
  logic          head_from_push_s;
  rsp_t          head_s;
  logic          out_vld_r;
  rsp_t          out_data_r;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full  = (cnt_r == CW'(DEPTH));
  assign empty = (cnt_r == {CW{1'b0}});
  // A full FIFO drops the push instead of corrupting the head entry.
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  // The incoming word becomes the head when nothing older survives this cycle.
  assign head_from_push_s = push_s &&
                            ((cnt_r == {CW{1'b0}}) || ((cnt_r == CW'(1)) && pop_s));

  // Next-state pointers, occupancy and head word.
  always_comb begin
    wr_nxt_s  = wr_ptr_r;
    rd_nxt_s  = rd_ptr_r;
    cnt_nxt_s = cnt_r;
    head_s    = '0;
    if (push_s) begin
      wr_nxt_s = ptr_inc(wr_ptr_r);
    end else begin
      wr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_nxt_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_nxt_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CW'(1);
      2'b01:   cnt_nxt_s = cnt_r - CW'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
    if (cnt_nxt_s == {CW{1'b0}}) begin
      head_s = '0;
    end else if (head_from_push_s) begin
      head_s = wdata;
    end else begin
      head_s = mem_r[rd_nxt_s];
    end
  end

  // Storage array; contents are don't-care until covered by the count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      out_vld_r  <= 1'b0;
      out_data_r <= '0;
    end else begin
      wr_ptr_r   <= wr_nxt_s;
      rd_ptr_r   <= rd_nxt_s;
      cnt_r      <= cnt_nxt_s;
      out_vld_r  <= (cnt_nxt_s != {CW{1'b0}});
      out_data_r <= head_s;
    end
  end

  assign out_vld  = out_vld_r;
  assign out_data = out_data_r;

endmodule

// File: rtl/align_rdq.sv
// align_rdq: valid/ready request front-end for the word-align stage.
// Tracks in-flight reads through the fixed align latency, captures returns in
// a credit-protected response FIFO, and optionally logs parity errors.
// Optional feature macro: ALIGN_RDQ_ERRLOG_EN (error log; tied off otherwise).
module align_rdq
  import align_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUMADDR    = 1024,
  parameter int BITADDR    = 10,
  parameter int BITPADR    = 10,
  parameter int SRAM_DELAY = 2,
  parameter int FLOPMEM    = 0,
  parameter int RSPDPTH    = 4,
  parameter int BITRSPD    = 3,
  parameter int BITECNT    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic               req_wr,
  input  logic [BITADDR-1:0] req_addr,
  input  logic [WIDTH-1:0]   req_din,
  output logic               read,
  output logic               write,
  output logic [BITADDR-1:0] addr,
  output logic [WIDTH-1:0]   din,
  input  logic [WIDTH-1:0]   dout,
  input  logic               serr,
  input  logic [BITPADR-1:0] padr,
  output logic               rsp_vld,
  input  logic               rsp_rdy,
  output logic [WIDTH-1:0]   rsp_dout,
  output logic               rsp_serr,
  output logic [BITPADR-1:0] rsp_padr,
  output logic               err_vld,
  output logic [BITPADR-1:0] err_padr,
  output logic [BITECNT-1:0] err_cnt,
  input  logic               err_clr
);

  localparam int LAT = rdq_lat(SRAM_DELAY, FLOPMEM);

  // Same layout as rdq_rsp_t, sized by this instance's parameters.
  typedef struct packed {
    logic [WIDTH-1:0]   dout;
    logic               serr;
    logic [BITPADR-1:0] padr;
  } rsp_t;

  logic               acc_s;
  logic               rd_acc_s;
  logic               pop_s;
  logic               push_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [LAT-1:0]     tag_r;
  logic [BITRSPD-1:0] cred_r;
  logic [BITRSPD-1:0] cred_nxt_s;
  logic               req_rdy_r;
  rsp_t               push_data_s;
  rsp_t               rsp_data_s;

  assign acc_s    = req_vld && req_rdy_r;
  assign rd_acc_s = acc_s && !req_wr;
  assign pop_s    = rsp_vld && rsp_rdy;
  assign push_s   = tag_r[LAT-1];
  assign req_rdy  = req_rdy_r;

  assign push_data_s.dout = dout;
  assign push_data_s.serr = serr;
  assign push_data_s.padr = padr;

  // Forward an accepted request to the align stage in the same cycle.
  always_comb begin
    read  = 1'b0;
    write = 1'b0;
    addr  = {BITADDR{1'b0}};
    din   = {WIDTH{1'b0}};
    if (acc_s) begin
      read  = !req_wr;
      write = req_wr;
      addr  = req_addr;
      din   = req_din;
    end else begin
      read  = 1'b0;
      write = 1'b0;
      addr  = {BITADDR{1'b0}};
      din   = {WIDTH{1'b0}};
    end
  end

  // Credits: reads in flight plus FIFO occupancy.
  always_comb begin
    cred_nxt_s = cred_r;
    case ({rd_acc_s, pop_s})
      2'b10:   cred_nxt_s = cred_r + BITRSPD'(1);
      2'b01:   cred_nxt_s = cred_r - BITRSPD'(1);
      default: cred_nxt_s = cred_r;
    endcase
  end

  // Credit counter and registered ready (no path from rsp_rdy to req_rdy).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred_r    <= {BITRSPD{1'b0}};
      req_rdy_r <= 1'b1;
    end else begin
      cred_r    <= cred_nxt_s;
      req_rdy_r <= (cred_nxt_s < BITRSPD'(RSPDPTH));
    end
  end

  // Read tags travel alongside the align pipeline; the exit bit pushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_r <= {LAT{1'b0}};
    end else begin
      tag_r[0] <= rd_acc_s;
      for (int i = 1; i < LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  align_rdq_fifo #(
    .DEPTH (RSPDPTH),
    .rsp_t (rsp_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .wdata    (push_data_s),
    .pop      (pop_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .out_vld  (rsp_vld),
    .out_data (rsp_data_s)
  );

  assign rsp_dout = rsp_data_s.dout;
  assign rsp_serr = rsp_data_s.serr;
  assign rsp_padr = rsp_data_s.padr;

`ifdef ALIGN_RDQ_ERRLOG_EN
  logic               err_vld_r;
  logic [BITPADR-1:0] err_padr_r;
  logic [BITECNT-1:0] err_cnt_r;

  // Error log: first failing padr, saturating count; clear beats a new error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_vld_r  <= 1'b0;
      err_padr_r <= {BITPADR{1'b0}};
      err_cnt_r  <= {BITECNT{1'b0}};
    end else if (err_clr) begin
      err_vld_r  <= 1'b0;
      err_padr_r <= {BITPADR{1'b0}};
      err_cnt_r  <= {BITECNT{1'b0}};
    end else if (push_s && serr) begin
      if (err_cnt_r != {BITECNT{1'b1}}) begin
        err_cnt_r <= err_cnt_r + BITECNT'(1);
      end
      if (!err_vld_r) begin
        err_vld_r  <= 1'b1;
        err_padr_r <= padr;
      end
    end
  end

  assign err_vld  = err_vld_r;
  assign err_padr = err_padr_r;
  assign err_cnt  = err_cnt_r;
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = err_clr;
  assign err_vld  = 1'b0;
  assign err_padr = {BITPADR{1'b0}};
  assign err_cnt  = {BITECNT{1'b0}};
`endif

  align_rdq_chk #(
    .NUMADDR (NUMADDR),
    .BITADDR (BITADDR)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .fifo_push  (push_s),
    .fifo_full  (fifo_full_s),
    .fifo_pop   (pop_s),
    .fifo_empty (fifo_empty_s),
    .req_acc    (acc_s),
    .req_addr   (req_addr)
  );

endmodule

// File: tb/tb_align_rdq.sv
// tb_align_rdq: directed bench for align_rdq with a stubbed 2-cycle align stage.
module tb_align_rdq;

`ifdef ALIGN_RDQ_ERRLOG_EN
  localparam bit ERRLOG = 1'b1;
`else
  localparam bit ERRLOG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld, req_rdy, req_wr;
  logic [9:0]  req_addr;
  logic [31:0] req_din;
  logic        read, write;
  logic [9:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        serr;
  logic [9:0]  padr;
  logic        rsp_vld, rsp_rdy, rsp_serr;
  logic [31:0] rsp_dout;
  logic [9:0]  rsp_padr;
  logic        err_vld, err_clr;
  logic [9:0]  err_padr;
  logic [1:0]  err_cnt;

  int total = 0;
  int bad   = 0;
  int issued, got, seen;

  always #5 clk = ~clk;

  align_rdq #(.BITECNT(2)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_din(req_din),
    .read(read), .write(write), .addr(addr), .din(din),
    .dout(dout), .serr(serr), .padr(padr),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dout(rsp_dout),
    .rsp_serr(rsp_serr), .rsp_padr(rsp_padr),
    .err_vld(err_vld), .err_padr(err_padr), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  // Stub align stage: 2-cycle read latency, padr = addr, serr set on request.
  logic       serr_en = 1'b0;
  logic       s1_v = 1'b0, s1_e = 1'b0, s2_v = 1'b0, s2_e = 1'b0;
  logic [9:0] s1_a = 10'h000, s2_a = 10'h000;

  function automatic logic [31:0] data_fn(input logic [9:0] a);
    if (a == 10'h005) return 32'hDEADBEEF;
    else return {12'hC0D, a, ~a};
  endfunction

  always @(posedge clk) begin
    s1_v <= read;  s1_e <= serr_en; s1_a <= addr;
    s2_v <= s1_v;  s2_e <= s1_e;    s2_a <= s1_a;
  end
  assign dout = data_fn(s2_a);
  assign serr = s2_v && s2_e;
  assign padr = s2_a;

  task automatic check_val(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    req_vld = 1'b0; req_wr = 1'b0; req_addr = 10'h000; req_din = 32'h0;
    rsp_rdy = 1'b1; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_req_rdy", req_rdy, 64'd1);
    check_val("rst_rsp_vld", rsp_vld, 64'd0);
    check_val("rst_rsp_dout", rsp_dout, 64'd0);
    check_val("rst_read", read, 64'd0);
    check_val("rst_err", {err_vld, err_padr, err_cnt}, 64'd0);
    check_val("rst_cred", dut.cred_r, 64'd0);
    step(); rst = 1'b0;

    // Read latency: accepted at T, rsp_vld at T+3.
    step(); req_vld = 1'b1; req_wr = 1'b0; req_addr = 10'h005;
    @(negedge clk);
    check_val("lat_read", read, 64'd1);
    check_val("lat_addr", addr, 64'h005);
    step(); req_vld = 1'b0;
    @(negedge clk); check_val("lat_t1_vld", rsp_vld, 64'd0);
    step(); @(negedge clk); check_val("lat_t2_vld", rsp_vld, 64'd0);
    step(); @(negedge clk);
    check_val("lat_t3_vld", rsp_vld, 64'd1);
    check_val("lat_dout", rsp_dout, 64'hDEADBEEF);
    check_val("lat_serr", rsp_serr, 64'd0);
    check_val("lat_padr", rsp_padr, 64'h005);
    step(); @(negedge clk);
    check_val("lat_t4_vld", rsp_vld, 64'd0);
    check_val("lat_cred", dut.cred_r, 64'd0);

    // Write: strobes forwarded, no response.
    step(); req_vld = 1'b1; req_wr = 1'b1; req_addr = 10'h007; req_din = 32'h12345678;
    @(negedge clk);
    check_val("wr_strobes", {read, write}, 64'b01);
    check_val("wr_din", din, 64'h12345678);
    step(); req_vld = 1'b0; req_wr = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); if (rsp_vld) seen++;
      step();
    end
    check_val("wr_no_rsp", seen, 64'd0);

    // Backpressure: 4 credits, 6 reads.
    rsp_rdy = 1'b0; issued = 0;
    for (int c = 0; c < 8; c++) begin
      step(); req_vld = 1'b1; req_addr = 10'(32'h20 + issued);
      @(negedge clk); if (req_rdy) issued++;
    end
    check_val("bp_accepted", issued, 64'd4);
    check_val("bp_rdy_low", req_rdy, 64'd0);
    check_val("bp_fifo_cnt", dut.u_fifo.cnt_r, 64'd4);
    check_val("bp_head", rsp_dout, 64'(data_fn(10'h020)));
    got = 0;
    for (int c = 0; c < 20; c++) begin
      step(); rsp_rdy = 1'b1; req_vld = (issued < 6); req_addr = 10'(32'h20 + issued);
      @(negedge clk);
      if (c == 0) check_val("bp_rdy_c0", req_rdy, 64'd0);
      if (c == 1) check_val("bp_rdy_c1", req_rdy, 64'd1);
      if (req_vld && req_rdy) issued++;
      if (rsp_vld) begin
        check_val("bp_order", rsp_dout, 64'(data_fn(10'(32'h20 + got))));
        got++;
      end
    end
    check_val("bp_issued", issued, 64'd6);
    check_val("bp_got", got, 64'd6);
    check_val("bp_cred", dut.cred_r, 64'd0);

    // Simultaneous push/pop with the FIFO at 3.
    step(); req_vld = 1'b0; rsp_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); req_vld = 1'b1; req_addr = 10'(32'h40 + k);
    end
    step(); req_vld = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check_val("sp_cnt3", dut.u_fifo.cnt_r, 64'd3);
    check_val("sp_cred3", dut.cred_r, 64'd3);
    step(); req_vld = 1'b1; req_addr = 10'h043;
    step(); req_vld = 1'b0;
    step(); rsp_rdy = 1'b1;
    @(negedge clk);
    check_val("sp_rdy_full", req_rdy, 64'd0);
    check_val("sp_head40", rsp_dout, 64'(data_fn(10'h040)));
    check_val("sp_cred4", dut.cred_r, 64'd4);
    step(); req_vld = 1'b1; req_addr = 10'h044;
    @(negedge clk);
    check_val("sp_cnt_pp", dut.u_fifo.cnt_r, 64'd3);
    check_val("sp_cred_pp", dut.cred_r, 64'd3);
    check_val("sp_head41", rsp_dout, 64'(data_fn(10'h041)));
    step(); req_vld = 1'b0;
    @(negedge clk);
    check_val("sp_cred_same", dut.cred_r, 64'd3);
    check_val("sp_cnt2", dut.u_fifo.cnt_r, 64'd2);
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_vld) begin
        check_val("sp_order", rsp_dout, 64'(data_fn(10'(32'h42 + got))));
        got++;
      end
      step(); @(negedge clk);
    end
    check_val("sp_got", got, 64'd3);
    check_val("sp_cred0", dut.cred_r, 64'd0);

    // Error log: errors on 0x012 and 0x034, clean read on 0x050.
    step(); serr_en = 1'b1; req_vld = 1'b1; req_addr = 10'h012;
    step(); req_addr = 10'h034;
    step(); serr_en = 1'b0; req_addr = 10'h050;
    step(); req_vld = 1'b0;
    @(negedge clk);
    check_val("el_rsp0", {rsp_vld, rsp_serr, rsp_padr}, {52'd0, 2'b11, 10'h012});
    step(); @(negedge clk);
    check_val("el_rsp1", {rsp_vld, rsp_serr, rsp_padr}, {52'd0, 2'b11, 10'h034});
    step(); @(negedge clk);
    check_val("el_rsp2", {rsp_vld, rsp_serr, rsp_padr}, {52'd0, 2'b10, 10'h050});
    check_val("el_vld", err_vld, ERRLOG ? 64'd1 : 64'd0);
    check_val("el_padr", err_padr, ERRLOG ? 64'h012 : 64'd0);
    check_val("el_cnt", err_cnt, ERRLOG ? 64'd2 : 64'd0);

    // Clear coinciding with a third error push.
    step(); serr_en = 1'b1; req_vld = 1'b1; req_addr = 10'h056;
    step(); req_vld = 1'b0; serr_en = 1'b0;
    step(); err_clr = 1'b1;
    step(); err_clr = 1'b0;
    @(negedge clk);
    check_val("clr_rsp_serr", {rsp_vld, rsp_serr}, 64'b11);
    check_val("clr_err", {err_vld, err_padr, err_cnt}, 64'd0);

    // Saturation: 5 errors on a 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      step(); serr_en = 1'b1; req_vld = 1'b1; req_addr = 10'(32'h70 + k);
    end
    step(); req_vld = 1'b0; serr_en = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check_val("sat_cnt", err_cnt, ERRLOG ? 64'd3 : 64'd0);
    check_val("sat_padr", err_padr, ERRLOG ? 64'h070 : 64'd0);
    check_val("sat_vld", err_vld, ERRLOG ? 64'd1 : 64'd0);

    // Reset with two reads in flight.
    step(); req_vld = 1'b1; req_addr = 10'h060;
    step(); req_addr = 10'h061;
    step(); req_vld = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_val("mr_rsp_vld", rsp_vld, 64'd0);
    check_val("mr_req_rdy", req_rdy, 64'd1);
    check_val("mr_cred", dut.cred_r, 64'd0);
    check_val("mr_err", {err_vld, err_cnt}, 64'd0);
    step(); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); if (rsp_vld) seen++;
      step();
    end
    check_val("mr_no_rsp", seen, 64'd0);
    check_val("mr_cred_after", dut.cred_r, 64'd0);
    check_val("mr_rdy_after", req_rdy, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
